// File: rtl/dht22_ctrl.sv
`timescale 1ns/1ps
// dht22_ctrl - single-wire controller for the DHT22 humidity/temperature
// sensor. Emulates an open-drain pin on a tri-state GPIO triple: dq_o is
// tied low and only dq_t toggles, so the line is either pulled low by the
// host or released to the external pull-up.
//
// A start request runs one full conversion: host start pulse, sensor
// response, 40-bit read, checksum test. Good reads update humidity and
// temperature; failures raise sticky error flags instead.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   start        single-cycle request, honoured only when idle
//   dq_i         raw (asynchronous) sensor line
//   dq_o         line drive value, constant 0
//   dq_t         tri-state enable, 1 = release, 0 = drive low
//   busy         conversion in progress
//   done         one-cycle pulse at the end of every conversion
//   humidity     RH x10 from the last good read
//   temperature  sign-magnitude degC x10 (bit 15 = sign), last good read
//   chk_err      checksum mismatch, sticky until next accepted start
//   tmo_err      edge timeout, sticky until next accepted start
//
// Optional feature: define DHT22_HOLDOFF_EN to add a HOLDOFF_MS quiet
// period after every conversion during which busy stays high and start
// is ignored.
module dht22_ctrl #(
  parameter int CLK_FREQ_HZ   = 100000000,
  parameter int START_LOW_US  = 1100,
  parameter int BIT_THRESH_US = 48,
  parameter int TIMEOUT_US    = 255
`ifdef DHT22_HOLDOFF_EN
  , parameter int HOLDOFF_MS  = 2000
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        dq_i,
  output logic        dq_o,
  output logic        dq_t,
  output logic        busy,
  output logic        done,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        chk_err,
  output logic        tmo_err
);

  localparam int CLK_PER_US = (CLK_FREQ_HZ / 1000000 < 1) ? 1 : CLK_FREQ_HZ / 1000000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_LOW,
    S_RELEASE,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK,
    S_FINISH,
    S_FAIL,
    S_HOLDOFF
  } state_t;

  state_t      state, state_nx;
  logic        dq_p0, dq_p1, dq_p2;
  logic [15:0] presc;
  logic        tick;
  logic [7:0]  us_cnt;
  logic [10:0] start_cnt;
  logic [5:0]  bit_cnt;
  logic [39:0] shreg;
  logic        rise, fall, tmo, bit_val, sum_ok;
  logic [7:0]  sum;
`ifdef DHT22_HOLDOFF_EN
  logic [9:0]  hold_us;
  logic [15:0] hold_ms;
  logic        hold_last;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign dq_o = 1'b0;

  // ---- p0/p1: two-flop synchronizer; p2: previous synced value for edges
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dq_p0 <= 1'b1;
      dq_p1 <= 1'b1;
      dq_p2 <= 1'b1;
    end else begin
      dq_p0 <= dq_i;
      dq_p1 <= dq_p0;
      dq_p2 <= dq_p1;
    end
  end

  assign rise    = dq_p1 & ~dq_p2;
  assign fall    = ~dq_p1 & dq_p2;
  assign tick    = (presc == 16'(CLK_PER_US - 1));
  assign tmo     = (us_cnt == 8'(TIMEOUT_US));
  assign bit_val = (us_cnt >= 8'(BIT_THRESH_US));
  assign sum     = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign sum_ok  = (sum == shreg[7:0]);
`ifdef DHT22_HOLDOFF_EN
  assign hold_last = tick && (hold_us == 10'd999) && (hold_ms == 16'(HOLDOFF_MS - 1));
`endif

  // ---- next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (start) state_nx = S_START_LOW;
      S_START_LOW: if (tick && start_cnt == 11'(START_LOW_US - 1)) state_nx = S_RELEASE;
      // Right after release the synchronizer still shows the host's own low
      // for a couple of cycles, so the sensor reply is taken as a falling
      // edge rather than a plain low level.
      S_RELEASE:   if (fall) state_nx = S_RESP_LOW;
                   else if (tmo) state_nx = S_FAIL;
      S_RESP_LOW:  if (rise) state_nx = S_RESP_HIGH;
                   else if (tmo) state_nx = S_FAIL;
      S_RESP_HIGH: if (fall) state_nx = S_BIT_LOW;
                   else if (tmo) state_nx = S_FAIL;
      S_BIT_LOW:   if (rise) state_nx = S_BIT_HIGH;
                   else if (tmo) state_nx = S_FAIL;
      S_BIT_HIGH:  if (fall) state_nx = (bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
                   else if (tmo) state_nx = S_FAIL;
      S_CHECK:     state_nx = S_FINISH;
`ifdef DHT22_HOLDOFF_EN
      S_FINISH,
      S_FAIL:      state_nx = S_HOLDOFF;
      S_HOLDOFF:   if (hold_last) state_nx = S_IDLE;
`else
      S_FINISH,
      S_FAIL:      state_nx = S_IDLE;
`endif
      default:     state_nx = S_IDLE;
    endcase
  end

  // ---- state, timers and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      presc       <= '0;
      us_cnt      <= '0;
      start_cnt   <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      dq_t        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      humidity    <= '0;
      temperature <= '0;
      chk_err     <= 1'b0;
      tmo_err     <= 1'b0;
`ifdef DHT22_HOLDOFF_EN
      hold_us     <= '0;
      hold_ms     <= '0;
`endif
    end else begin
      state <= state_nx;

      // Tick phase and us counter restart on every state change so each
      // phase is measured from its own entry.
      if (state_nx != state) begin
        presc  <= '0;
        us_cnt <= '0;
      end else if (tick) begin
        presc  <= '0;
        us_cnt <= sat_inc8(us_cnt);
      end else begin
        presc  <= presc + 16'd1;
      end

      if (state != S_START_LOW) start_cnt <= '0;
      else if (tick)            start_cnt <= start_cnt + 11'd1;

`ifdef DHT22_HOLDOFF_EN
      if (state != S_HOLDOFF) begin
        hold_us <= '0;
        hold_ms <= '0;
      end else if (tick) begin
        if (hold_us == 10'd999) begin
          hold_us <= '0;
          hold_ms <= hold_ms + 16'd1;
        end else begin
          hold_us <= hold_us + 10'd1;
        end
      end
      busy <= (state_nx != S_IDLE);
`else
      busy <= !(state_nx inside {S_IDLE, S_FINISH, S_FAIL});
`endif
      dq_t <= (state_nx != S_START_LOW);
      done <= (state_nx == S_FINISH) || (state_nx == S_FAIL);

      if (state == S_IDLE && start) begin
        chk_err <= 1'b0;
        tmo_err <= 1'b0;
        shreg   <= '0;
        bit_cnt <= '0;
      end

      if (state == S_BIT_HIGH && fall) begin
        shreg   <= {shreg[38:0], bit_val};
        bit_cnt <= bit_cnt + 6'd1;
      end

      if (state == S_CHECK) begin
        if (sum_ok) begin
          humidity    <= shreg[39:24];
          temperature <= shreg[23:8];
        end else begin
          chk_err     <= 1'b1;
        end
      end

      // Only timeouts lead to FAIL; any partial frame is dropped there.
      if (state_nx == S_FAIL && state != S_FAIL) tmo_err <= 1'b1;
      if (state_nx == S_FINISH || state_nx == S_FAIL) bit_cnt <= '0;
    end
  end

endmodule
